digit_step_counter: RTL and testbench
=====================================

// Module: digit_step_counter
// PURPOSE
//   Produces a decimal digit that advances at a slow, divided rate from the
//   fabric clock (Sys_Clk0), and drives the seven-segment pins a..g with it.
//   Made of a prescaler, a mod-10 up/down counter with load, and a registered
//   active-low segment decoder. It feeds the top-level seven-segment pins
//   directly, replacing per-segment hard-wired LED assignments.
// PARAMETERS
//   TICK_DIV  20_000_000  clk cycles per digit step (legal range >= 2)
//   CNT_W     $clog2(TICK_DIV)  prescaler width (derived; do not override)
// PORTS
//   clk       in   1  fabric clock (Sys_Clk0)
//   rst_n     in   1  synchronous reset, active-low
//   en        in   1  run: prescaler counts only while high
//   up        in   1  1 = count up, 0 = count down (sampled on the tick)
//   load      in   1  1-cycle strobe: load load_val into digit
//   load_val  in   4  value to load (legal 0..9)
//   blank     in   1  1 = all segments off
//   tick      out  1  1-cycle pulse at each digit step (registered)
//   digit     out  4  current digit 0..9 (registered)
//   carry     out  1  1-cycle pulse when digit wraps 9->0 or 0->9
//   seg_n     out  7  {g,f,e,d,c,b,a}; 0 = segment lit (common anode)
// BEHAVIOUR
//   Clock/reset: single clock domain. rst_n is synchronous, active-low, and
//     overrides everything, including in the middle of a prescale period.
//   Reset values: prescaler=0, tick=0, digit=0, carry=0, seg_n=7'b1000000
//     (digit "0" shown).
//   Prescaler: while en=1, count 0..TICK_DIV-1, then wrap to 0. tick=1 in
//     the cycle after count==TICK_DIV-1 is seen. Period is exactly TICK_DIV
//     cycles. While en=0, the count holds and tick=0.
//   Digit update (evaluated each cycle, in priority order):
//     1. load=1: if load_val<=9, digit<=load_val; else digit is unchanged.
//        In both cases the prescaler clears to 0, tick=0 and carry=0.
//        A load that arrives in the same cycle as a step wins; the step is
//        lost.
//     2. Else, on the internal step condition (same cycle tick is set):
//        up=1: digit+1, with 9->0 setting carry=1.
//        up=0: digit-1, with 0->9 setting carry=1.
//        digit and tick assert in the same cycle.
//     3. Else digit holds and carry=0.
//   Arithmetic: mod-10 only; digit never leaves 0..9.
//   Decoder: seg_n is registered from digit and blank, so the display lags
//     digit by 1 cycle. blank=1 gives seg_n=7'h7F one cycle later.
//     Table (digit: seg_n):
//       0:1000000  1:1111001  2:0100100  3:0110000  4:0011001
//       5:0010010  6:0000010  7:1111000  8:0000000  9:0010000
//   en deasserted mid-period: remaining count resumes when en returns;
//     the prescaler does not restart.
// TESTING (bench uses TICK_DIV=4)
//   1 Reset, en=1, up=1 -> tick every 4 cycles; digit goes 0,1,..9,0;
//     carry pulses once, on the same cycle digit becomes 0.
//   2 digit=0, up=0, one step -> digit=9, carry=1 for 1 cycle;
//     next cycle seg_n=0010000.
//   3 load=1, load_val=7, coinciding with a step -> digit=7, no carry,
//     next tick 4 cycles later; load_val=12 -> digit unchanged.
//   4 en=0 held for 10 cycles mid-period -> no tick, digit stable;
//     after en=1, tick arrives after the remaining count, not after 4.
//   5 blank=1 -> seg_n=7F one cycle later; blank=0 -> the digit pattern
//     returns; digit keeps counting throughout.
//   6 rst_n=0 for 1 cycle at digit=5, mid-period -> next cycle digit=0,
//     seg_n=1000000, prescaler=0, tick=carry=0.

Source files
------------

// File: rtl/digit_step_counter.sv
// digit_step_counter: prescaled mod-10 up/down digit with load
// and a registered active-low seven-segment decoder.
module digit_step_counter #(
   parameter int TICK_DIV = 20_000_000,
   parameter int CNT_W    = $clog2(TICK_DIV)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       blank,
   output logic       tick,
   output logic [3:0] digit,
   output logic       carry,
   output logic [6:0] seg_n
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;
   logic             step;
   logic             wrap;
   logic [3:0]       dig_nxt;
   logic [6:0]       seg_nxt;

   assign step = en && (cnt == LAST);

   // prescaler: counts only while enabled, cleared by load or wrap
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load || step) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // mod-10 neighbour of the current digit in the chosen direction
   always_comb begin
      dig_nxt = digit;
      wrap    = 1'b0;
      if (up) begin
         if (digit == 4'd9) begin
            dig_nxt = 4'd0;
            wrap    = 1'b1;
         end else begin
            dig_nxt = digit + 4'd1;
         end
      end else begin
         if (digit == 4'd0) begin
            dig_nxt = 4'd9;
            wrap    = 1'b1;
         end else begin
            dig_nxt = digit - 4'd1;
         end
      end
   end

   // digit, tick and carry: load beats a coincident step
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         digit <= 4'd0;
         tick  <= 1'b0;
         carry <= 1'b0;
      end else if (load) begin
         if (load_val <= 4'd9) begin
            digit <= load_val;
         end
         tick  <= 1'b0;
         carry <= 1'b0;
      end else if (step) begin
         digit <= dig_nxt;
         tick  <= 1'b1;
         carry <= wrap;
      end else begin
         tick  <= 1'b0;
         carry <= 1'b0;
      end
   end

   // segment pattern for the current digit, {g,f,e,d,c,b,a}, 0 = lit
   always_comb begin
      seg_nxt = 7'h7F;
      if (!blank) begin
         case (digit)
            4'd0:    seg_nxt = 7'b1000000;
            4'd1:    seg_nxt = 7'b1111001;
            4'd2:    seg_nxt = 7'b0100100;
            4'd3:    seg_nxt = 7'b0110000;
            4'd4:    seg_nxt = 7'b0011001;
            4'd5:    seg_nxt = 7'b0010010;
            4'd6:    seg_nxt = 7'b0000010;
            4'd7:    seg_nxt = 7'b1111000;
            4'd8:    seg_nxt = 7'b0000000;
            4'd9:    seg_nxt = 7'b0010000;
            default: seg_nxt = 7'h7F;
         endcase
      end
   end

   // registered segment outputs, one cycle behind digit
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_n <= 7'b1000000;
      end else begin
         seg_n <= seg_nxt;
      end
   end

endmodule

// File: tb/tb_digit_step_counter.sv
// tb_digit_step_counter: directed and random checks of the
// prescaled digit counter against a cycle-level reference model.
module tb_digit_step_counter;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       load;
   logic [3:0] load_val;
   logic       blank;
   logic       tick;
   logic [3:0] digit;
   logic       carry;
   logic [6:0] seg_n;

   int checks   = 0;
   int failures = 0;

   logic [6:0] segtab [10] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
      7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
   };

   int         m_dig;
   int         m_rem;
   logic       m_tick;
   logic       m_carry;
   logic [6:0] m_seg;

   digit_step_counter #(.TICK_DIV(TD)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .up       (up),
      .load     (load),
      .load_val (load_val),
      .blank    (blank),
      .tick     (tick),
      .digit    (digit),
      .carry    (carry),
      .seg_n    (seg_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [6:0] obs,
                      input logic [6:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // one clock: drive inputs, advance model, compare all outputs
   task automatic clk1(input logic r, input logic e, input logic u,
                       input logic l, input logic [3:0] lv,
                       input logic b);
      logic [6:0] ns;
      rst_n = r; en = e; up = u; load = l; load_val = lv; blank = b;
      @(posedge clk);
      ns = b ? 7'h7F : segtab[m_dig];
      if (!r) begin
         m_dig = 0; m_rem = TD; m_tick = 0; m_carry = 0;
         m_seg = 7'b1000000;
      end else begin
         m_seg = ns;
         if (l) begin
            if (lv <= 9) m_dig = int'(lv);
            m_rem = TD; m_tick = 0; m_carry = 0;
         end else if (e && m_rem == 1) begin
            m_rem = TD;
            m_tick = 1;
            if (u) begin
               m_carry = (m_dig == 9);
               m_dig = (m_dig + 1) % 10;
            end else begin
               m_carry = (m_dig == 0);
               m_dig = (m_dig + 9) % 10;
            end
         end else begin
            if (e) m_rem--;
            m_tick = 0;
            m_carry = 0;
         end
      end
      #1;
      chk("tick",  {6'd0, tick},  {6'd0, m_tick});
      chk("digit", {3'd0, digit}, 7'(m_dig));
      chk("carry", {6'd0, carry}, {6'd0, m_carry});
      chk("seg_n", seg_n, m_seg);
   endtask

   initial begin
      int n;
      int ncar;
      int nt;
      bit got;
      int d0;
      rst_n = 0; en = 0; up = 1; load = 0; load_val = 0; blank = 0;
      m_dig = 0; m_rem = TD; m_tick = 0; m_carry = 0; m_seg = 7'h40;

      // reset state
      clk1(0, 0, 1, 0, 0, 0);
      clk1(0, 0, 1, 0, 0, 0);
      chk("rst_digit", {3'd0, digit}, 7'd0);
      chk("rst_seg", seg_n, 7'b1000000);
      chk("rst_tick", {6'd0, tick}, 7'd0);
      chk("rst_carry", {6'd0, carry}, 7'd0);

      // count up through a full decade
      ncar = 0;
      for (int i = 0; i < 40; i++) begin
         clk1(1, 1, 1, 0, 0, 0);
         if (carry === 1'b1) begin
            ncar++;
            chk("carry_at_zero", {3'd0, digit}, 7'd0);
         end
      end
      chk("carry_count", 7'(ncar), 7'd1);
      chk("decade_digit", {3'd0, digit}, 7'd0);

      // down-step from 0 wraps to 9
      clk1(1, 1, 0, 1, 4'd0, 0);
      for (int i = 0; i < 4; i++) clk1(1, 1, 0, 0, 0, 0);
      chk("down_digit", {3'd0, digit}, 7'd9);
      chk("down_carry", {6'd0, carry}, 7'd1);
      clk1(1, 1, 0, 0, 0, 0);
      chk("down_seg", seg_n, 7'b0010000);
      chk("down_carry_off", {6'd0, carry}, 7'd0);

      // load coinciding with a step
      clk1(1, 1, 1, 1, 4'd3, 0);
      for (int i = 0; i < 3; i++) clk1(1, 1, 1, 0, 0, 0);
      clk1(1, 1, 1, 1, 4'd7, 0);
      chk("ld_digit", {3'd0, digit}, 7'd7);
      chk("ld_tick", {6'd0, tick}, 7'd0);
      chk("ld_carry", {6'd0, carry}, 7'd0);
      n = 0; got = 0;
      for (int i = 1; i <= 8 && !got; i++) begin
         clk1(1, 1, 1, 0, 0, 0);
         if (tick === 1'b1) begin got = 1; n = i; end
      end
      chk("ld_tick_delay", 7'(n), 7'd4);
      clk1(1, 1, 1, 1, 4'd12, 0);
      chk("ld_illegal", {3'd0, digit}, 7'd8);

      // enable pause mid-period
      clk1(1, 1, 1, 1, 4'd2, 0);
      clk1(1, 1, 1, 0, 0, 0);
      clk1(1, 1, 1, 0, 0, 0);
      nt = 0;
      for (int i = 0; i < 10; i++) begin
         clk1(1, 0, 1, 0, 0, 0);
         if (tick === 1'b1) nt++;
      end
      chk("pause_ticks", 7'(nt), 7'd0);
      chk("pause_digit", {3'd0, digit}, 7'd2);
      n = 0; got = 0;
      for (int i = 1; i <= 8 && !got; i++) begin
         clk1(1, 1, 1, 0, 0, 0);
         if (tick === 1'b1) begin got = 1; n = i; end
      end
      chk("resume_delay", 7'(n), 7'd2);
      chk("resume_digit", {3'd0, digit}, 7'd3);

      // blanking while counting
      clk1(1, 1, 1, 0, 0, 1);
      chk("blank_seg", seg_n, 7'h7F);
      for (int i = 0; i < 8; i++) clk1(1, 1, 1, 0, 0, 1);
      chk("blank_digit", {3'd0, digit}, 7'd5);
      d0 = m_dig;
      clk1(1, 1, 1, 0, 0, 0);
      chk("unblank_seg", seg_n, segtab[d0]);

      // reset mid-period at digit 5
      clk1(1, 1, 1, 1, 4'd5, 0);
      clk1(1, 1, 1, 0, 0, 0);
      clk1(1, 1, 1, 0, 0, 0);
      clk1(0, 1, 1, 0, 0, 0);
      chk("mrst_digit", {3'd0, digit}, 7'd0);
      chk("mrst_seg", seg_n, 7'b1000000);
      chk("mrst_tick", {6'd0, tick}, 7'd0);
      chk("mrst_carry", {6'd0, carry}, 7'd0);
      n = 0; got = 0;
      for (int i = 1; i <= 8 && !got; i++) begin
         clk1(1, 1, 1, 0, 0, 0);
         if (tick === 1'b1) begin got = 1; n = i; end
      end
      chk("mrst_tick_delay", 7'(n), 7'd4);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         clk1($urandom_range(99) != 0,
              $urandom_range(3) != 0,
              1'($urandom_range(1)),
              $urandom_range(19) == 0,
              4'($urandom_range(15)),
              $urandom_range(4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
